// File: rtl/minhash_topk_sorter.sv
// Streaming bottom-K MinHash sorter: keeps the DEPTH smallest signatures of a
// fragment sorted ascending, then drains them in rank order under ready/valid.
module minhash_topk_sorter #(
  parameter int unsigned SIG_W = 32,
  parameter int unsigned IDX_W = 7,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned POS_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter bit          DEDUP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIG_W-1:0] in_sig,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] out_sig,
  output logic [IDX_W-1:0] out_idx,
  output logic [POS_W-1:0] out_pos,
  output logic             out_last
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t           state_q;
  logic [SIG_W-1:0] sig_q [DEPTH];
  logic [IDX_W-1:0] idx_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [CNT_W-1:0] count_q;
  logic [POS_W-1:0] rd_ptr_q;

  logic             accept;
  logic [CNT_W-1:0] ins_pos;
  logic             dup;
  logic             drop;
  logic [SIG_W-1:0] sig_n [DEPTH];
  logic [IDX_W-1:0] idx_n [DEPTH];
  logic [DEPTH-1:0] vld_n;
  logic [CNT_W-1:0] count_n;
  logic [SIG_W-1:0] sh_sig [DEPTH];
  logic [IDX_W-1:0] sh_idx [DEPTH];
  logic [DEPTH-1:0] sh_vld;
  logic [POS_W-1:0] nxt_ptr;
  logic [SIG_W-1:0] nxt_sig;
  logic [IDX_W-1:0] nxt_idx;

  assign accept = in_valid & in_ready;

  // Insertion rank: entries <= in_sig stay ahead of the new one (stable ties)
  always_comb begin
    ins_pos = '0;
    dup     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) begin
        if (sig_q[i] <= in_sig) ins_pos = ins_pos + CNT_W'(1);
        if (sig_q[i] == in_sig) dup = 1'b1;
      end
    end
  end

  assign drop = (DEDUP && dup) || (ins_pos == CNT_W'(DEPTH));

  // Array view shifted up by one slot; the top slot falls off (eviction)
  always_comb begin
    sh_sig[0] = '0;
    sh_idx[0] = '0;
    sh_vld    = '0;
    for (int i = 1; i < DEPTH; i++) begin
      sh_sig[i] = sig_q[i-1];
      sh_idx[i] = idx_q[i-1];
      sh_vld[i] = vld_q[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      sig_n[i] = sig_q[i];
      idx_n[i] = idx_q[i];
    end
    vld_n   = vld_q;
    count_n = count_q;
    if (accept && !drop) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == ins_pos) begin
          sig_n[i] = in_sig;
          idx_n[i] = in_idx;
          vld_n[i] = 1'b1;
        end else if (CNT_W'(i) > ins_pos) begin
          sig_n[i] = sh_sig[i];
          idx_n[i] = sh_idx[i];
          vld_n[i] = sh_vld[i];
        end
      end
      if (count_q != CNT_W'(DEPTH)) count_n = count_q + CNT_W'(1);
    end
  end

  // Entry that follows the one currently presented; guarded for non-pow2 DEPTH
  always_comb begin
    nxt_ptr = rd_ptr_q + POS_W'(1);
    nxt_sig = '0;
    nxt_idx = '0;
    if (32'(nxt_ptr) < DEPTH) begin
      nxt_sig = sig_q[nxt_ptr];
      nxt_idx = idx_q[nxt_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      for (int i = 0; i < DEPTH; i++) begin
        sig_q[i] <= '0;
        idx_q[i] <= '0;
      end
      vld_q     <= '0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sig   <= '0;
      out_idx   <= '0;
      out_pos   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            sig_q   <= sig_n;
            idx_q   <= idx_n;
            vld_q   <= vld_n;
            count_q <= count_n;
            if (in_last) begin
              state_q   <= DRAIN;
              rd_ptr_q  <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sig   <= sig_n[0];
              out_idx   <= idx_n[0];
              out_pos   <= '0;
              out_last  <= (count_n == CNT_W'(1));
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              state_q   <= COLLECT;
              vld_q     <= '0;
              count_q   <= '0;
              rd_ptr_q  <= '0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_sig   <= '0;
              out_idx   <= '0;
              out_pos   <= '0;
              out_last  <= 1'b0;
            end else begin
              rd_ptr_q <= nxt_ptr;
              out_sig  <= nxt_sig;
              out_idx  <= nxt_idx;
              out_pos  <= nxt_ptr;
              out_last <= (CNT_W'(nxt_ptr) == count_q - CNT_W'(1));
            end
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: doc/minhash_topk_sorter.md
Name: minhash_topk_sorter

Overview:
- Streaming bottom-K MinHash sorter; successor to the fixed 4-entry sorter, with parametrised depth and widths, optional duplicate suppression, and ready/valid backpressure on both sides.
- Sits between the hasher and the extender.
- Per fragment, it accepts (signature, index) pairs from the hasher and keeps the DEPTH smallest signatures sorted ascending.
- On end-of-fragment it drains them in rank order to the extender.

Parameters:
- SIG_W, 32, signature width (matches HASHER_SORTER_SIGNATURE).
- IDX_W, 7, index width (matches INDICE_LEN).
- DEPTH, 4, number of retained minima; must be >= 1.
- POS_W, $clog2(DEPTH) (1 when DEPTH=1), rank field width.
- DEDUP, 1, 1 = drop an incoming signature equal to one already held.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pair valid.
- in_ready  out  1  sorter can accept a pair.
- in_sig  in  SIG_W  signature.
- in_idx  in  IDX_W  fragment index of signature.
- in_last  in  1  final pair of fragment.
- out_valid  out  1  output pair valid.
- out_ready  in  1  extender accepts output.
- out_sig  out  SIG_W  sorted signature.
- out_idx  out  IDX_W  its index.
- out_pos  out  POS_W  rank (0 = smallest).
- out_last  out  1  final output of fragment.

Behaviour:
- Reset is asynchronous, active-low, with immediate effect:
  - state=COLLECT, all DEPTH entry valid bits cleared, count=0, rd_ptr=0.
  - Outputs: in_ready=1, out_valid=0, out_sig=0, out_idx=0, out_pos=0, out_last=0.
- Storage: DEPTH registers {sig, idx, vld}, kept sorted ascending by sig; valid entries are contiguous from slot 0.
- State COLLECT:
  - in_ready=1, out_valid=0.
  - Accept = in_valid & in_ready. One pair is processed per cycle and the array updates on the accepting edge.
- Insertion position p = number of valid entries with sig <= in_sig (unsigned compare). Ties place the new entry after existing equals, giving arrival-order stability.
- DEDUP=1 and any valid entry has sig == in_sig: pair dropped, array unchanged.
- count < DEPTH: entries p..count-1 shift up one slot, new entry written at p, count+1.
- count == DEPTH and p < DEPTH: entries shift up, slot DEPTH-1 is evicted, new entry written at p, count unchanged.
- count == DEPTH and p == DEPTH: pair dropped.
- in_last on an accepted pair:
  - The insert/drop rules above are applied to that pair, then state goes to DRAIN next cycle and rd_ptr=0.
  - count >= 1 is guaranteed at entry to DRAIN, since any pair into an empty array is inserted.
- State DRAIN:
  - in_ready=0; in_valid is ignored and no data is lost upstream.
  - out_valid=1 (registered, asserted the cycle after the last-pair accept).
  - out_sig/out_idx = entry[rd_ptr], out_pos = rd_ptr, out_last = (rd_ptr == count-1).
  - out_valid & out_ready: rd_ptr+1.
  - If out_last was set, instead: clear all valid bits, count=0, rd_ptr=0, return to COLLECT. in_ready=1 on the following cycle.
  - While out_ready=0 all out_* stay stable.
- Latency:
  - Last input accepted at edge N gives first output valid after edge N.
  - Full-throughput drain takes count cycles; minimum turnaround is 1 idle cycle between fragments.
- No combinational path from in_valid or out_ready to any output other than via registered state.

Test Plan:
- Basic sort (DEPTH=4, DEDUP=1): sigs 40,10,30,20 (idx 0..3, last on 4th) -> outputs sig 10,20,30,40 / idx 1,3,2,0 / pos 0..3, out_last only on 40, first out_valid one cycle after last accept.
- Overflow/eviction: 50,40,30,20,10,60(last) -> exactly 4 outputs 10,20,30,40; 50 evicted, 60 dropped.
- Duplicates: 5(idx0),5(idx1),7(idx2,last):
  - DEDUP=1 -> 5/idx0, 7/idx2, out_last on 7.
  - DEDUP=0 -> 5/idx0, 5/idx1, 7/idx2 in that order.
- Backpressure: basic-sort stimulus with out_ready toggling 1,0,0,1,... and in_valid held high during drain -> out_* stable while stalled, in_ready=0 throughout DRAIN, no extra inputs absorbed, sequence identical to unstalled run.
- Single-item fragment: one pair sig 0xFFFFFFFF idx 127 with in_last -> one output, pos 0, out_last=1; back in COLLECT with in_ready=1 one cycle later.
- Reset mid-drain: assert rst_n=0 after second output of basic sort -> out_valid=0, in_ready=1 immediately; next fragment 9(last) outputs only 9 with out_last=1, no stale entries.
